// File: rtl/rand_txn_gen.sv
// Multi-channel random valid/data stimulus generator with a pass/timeout
// state machine. Each channel issues valid/ready transactions drawn from one
// shared Galois LFSR. The run ends in PASS once every channel has reached its
// target count, or in FAIL when the run-cycle budget is exhausted.
module rand_txn_gen #(
    parameter int          NUM_CH      = 1,
    parameter int          DATA_W      = 8,
    parameter int          VALID_THR   = 128,
    parameter int          MODE        = 0,
    parameter logic [31:0] SEED        = 32'h1,
    parameter int          TARGET_TXNS = 16,
    parameter int          MAX_CYCLES  = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic [NUM_CH-1:0]        in_ready,
    output logic [NUM_CH*16-1:0]     txn_cnt,
    output logic                     passed,
    output logic                     failed
);

    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [8:0]  THR       = 9'(VALID_THR);
    localparam logic [15:0] TARGET    = 16'(TARGET_TXNS);
    localparam logic [16:0] MAX       = 17'(MAX_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [31:0]              lfsr_q;
    logic [31:0]              lfsr_next;
    logic [15:0]              run_cnt_q;
    logic [NUM_CH*DATA_W-1:0] seq_q;
    logic [NUM_CH-1:0]        accept;
    logic [NUM_CH-1:0]        want_valid;
    logic [7:0]               draw_lo  [NUM_CH];
    logic [DATA_W-1:0]        draw_dat [NUM_CH];
    logic                     all_done;
    logic                     timeout;

    // Channel c sees the LFSR state rotated left by c whole bytes, so the
    // channels get distinct draws from a single generator.
    function automatic logic [31:0] rotl_bytes(input logic [31:0] v, input int c);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < c; i++) begin
            r = {r[23:0], r[31:24]};
        end
        return r;
    endfunction

    // Galois step: shift right and fold in the tap mask when the bit shifted out is 1
    always_comb begin
        lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    end

    // Per-channel draws, handshakes, and the pass/timeout conditions for this edge
    always_comb begin
        accept     = out_valid & in_ready;
        want_valid = '0;
        all_done   = 1'b1;
        timeout    = (({1'b0, run_cnt_q} + 17'd1) == MAX);
        for (int c = 0; c < NUM_CH; c++) begin
            draw_lo[c]    = 8'(rotl_bytes(lfsr_q, c));
            draw_dat[c]   = DATA_W'(rotl_bytes(lfsr_q, c));
            want_valid[c] = !out_valid[c] &&
                            (txn_cnt[c*16 +: 16] < TARGET) &&
                            ({1'b0, draw_lo[c]} < THR);
            if ((txn_cnt[c*16 +: 16] + {15'd0, accept[c]}) != TARGET) begin
                all_done = 1'b0;
            end
        end
    end

    // Next state: leave IDLE at once; in RUN completion wins over timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN: begin
                if (all_done) begin
                    state_d = PASS;
                end else if (timeout) begin
                    state_d = FAIL;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky result flags follow the terminal state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            passed <= 1'b0;
            failed <= 1'b0;
        end else begin
            passed <= (state_d == PASS);
            failed <= (state_d == FAIL);
        end
    end

    // Channel datapath: raise, hold and retire transactions; advance LFSR and run counter in RUN only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
            txn_cnt   <= '0;
            seq_q     <= '0;
            lfsr_q    <= SEED_EFF;
            run_cnt_q <= '0;
        end else if (state_q == RUN) begin
            lfsr_q <= lfsr_next;
            if (run_cnt_q != 16'hFFFF) begin
                run_cnt_q <= run_cnt_q + 16'd1;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept[c]) begin
                    out_valid[c] <= 1'b0;
                    if (txn_cnt[c*16 +: 16] < TARGET) begin
                        txn_cnt[c*16 +: 16] <= txn_cnt[c*16 +: 16] + 16'd1;
                    end
                    if (MODE == 1) begin
                        seq_q[c*DATA_W +: DATA_W] <= seq_q[c*DATA_W +: DATA_W] + DATA_W'(1);
                    end
                end else if (want_valid[c] && (state_d == RUN)) begin
                    out_valid[c]                 <= 1'b1;
                    out_data[c*DATA_W +: DATA_W] <= (MODE == 1) ? seq_q[c*DATA_W +: DATA_W]
                                                                : draw_dat[c];
                end
            end
            if (state_d != RUN) begin
                out_valid <= '0;
            end
        end else begin
            out_valid <= '0;
        end
    end

endmodule

// File: doc/rand_txn_gen.md
RAND_TXN_GEN -- requirements
Module: rand_txn_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 1: number of independent stimulus channels, legal 1..4.
REQ-002 SHALL have parameter DATA_W, default 8: data width per channel, legal 1..32.
REQ-003 SHALL have parameter VALID_THR, default 128: valid probability threshold out of 256, legal 0..256.
REQ-004 SHALL have parameter MODE, default 0: 0 = random data, 1 = per-channel incrementing data.
REQ-005 SHALL have parameter SEED, default 32'h1: LFSR seed; a value of 0 SHALL be replaced by 32'h1.
REQ-006 SHALL have parameter TARGET_TXNS, default 16: accepted transactions required per channel, legal 1..65535.
REQ-007 SHALL have parameter MAX_CYCLES, default 1000: timeout in RUN cycles, legal 1..65535.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port out_valid, output, NUM_CH bits: per-channel transaction valid.
REQ-011 SHALL have port out_data, output, NUM_CH*DATA_W bits: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-012 SHALL have port in_ready, input, NUM_CH bits: per-channel consumer ready.
REQ-013 SHALL have port txn_cnt, output, NUM_CH*16 bits: per-channel accepted-transaction count.
REQ-014 SHALL have port passed, output, 1 bit: test passed, sticky.
REQ-015 SHALL have port failed, output, 1 bit: timeout, sticky.

Function
REQ-016 SHALL implement a state machine with states IDLE, RUN, PASS and FAIL.
REQ-017 SHALL enter IDLE on reset and move IDLE->RUN on the first clock edge after reset deasserts.
REQ-018 SHALL treat PASS and FAIL as terminal; only reset leaves them.
REQ-019 SHALL use a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003), loaded with SEED on reset and advanced once per cycle in RUN only.
REQ-020 SHALL define, per channel c, a draw r_c = the LFSR state rotated left by 8*c.
REQ-021 SHALL, in RUN, assert out_valid[c] on the next edge when out_valid[c] is low and r_c[7:0] < VALID_THR; VALID_THR=0 never asserts valid and 256 always asserts it.
REQ-022 SHALL load out_data for channel c in the same edge valid rises: MODE 0 uses r_c[DATA_W-1:0]; MODE 1 uses the channel's sequence counter, reset value 0.
REQ-023 SHALL count an acceptance when out_valid[c] and in_ready[c] are both high at a clock edge.
REQ-024 SHALL hold out_valid[c] and out_data for channel c stable while out_valid[c]=1 and in_ready[c]=0.
REQ-025 SHALL, on acceptance, drop out_valid[c] for at least one cycle (no back-to-back valids), increment txn_cnt[c], and in MODE 1 increment the sequence counter modulo 2^DATA_W.
REQ-026 SHALL saturate txn_cnt[c] at TARGET_TXNS; a channel at target SHALL assert no further valids.
REQ-027 SHALL keep a 16-bit run-cycle counter that starts at 0 on entering RUN, increments each RUN cycle and saturates.
REQ-028 SHALL transition RUN->PASS when every txn_cnt[c] equals TARGET_TXNS.
REQ-029 SHALL transition RUN->FAIL when the run-cycle counter reaches MAX_CYCLES with the pass condition false.
REQ-030 SHALL give PASS priority when the pass and timeout conditions occur in the same cycle.
REQ-031 SHALL drive passed=1 in PASS and failed=1 in FAIL, registered, never both high.
REQ-032 SHALL force out_valid to 0 in IDLE, PASS and FAIL; a valid pending on entry to PASS/FAIL SHALL be dropped without counting.
REQ-033 SHALL ignore in_ready while out_valid[c]=0.

Reset
REQ-034 SHALL, on reset assertion at any time (including mid-handshake), asynchronously force out_valid=0, out_data=0, txn_cnt=0, passed=0, failed=0, state=IDLE, LFSR=SEED, and sequence counters and run-cycle counter to 0.
REQ-035 SHALL make no acceptance or count update on any edge where reset is high.

Verification
REQ-036 SHALL verify: NUM_CH=1, MODE=1, VALID_THR=256, in_ready=1 constantly, TARGET_TXNS=4 -> data 0,1,2,3 on alternate cycles; passed=1 within 10 cycles of reset release; failed stays 0.
REQ-037 SHALL verify: in_ready=0 for 20 cycles after the first valid -> out_valid and out_data unchanged for all 20 cycles; txn_cnt stays 0.
REQ-038 SHALL verify: VALID_THR=0, MAX_CYCLES=50 -> out_valid never high; failed=1 after 50 RUN cycles; passed=0.
REQ-039 SHALL verify: NUM_CH=4, MODE=0, VALID_THR=128, random in_ready -> each channel's data matches a reference-model LFSR; all txn_cnt reach TARGET_TXNS; passed=1.
REQ-040 SHALL verify: reset asserted mid-run while out_valid=1 -> all outputs 0 immediately without a clock edge; after release, the sequence repeats identically from SEED.
REQ-041 SHALL verify: parameters chosen so the final acceptance lands on cycle MAX_CYCLES -> passed=1, failed=0.
